// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: bus widths,
// ALU-op encodings, divider FSM state encodings and an op classifier.
package ex_muldiv_pkg;

  localparam int unsigned REG_BUS_W    = 32;
  localparam int unsigned ALU_OP_BUS_W = 8;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

  localparam logic [ALU_OP_BUS_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;

  // Divider FSM encodings kept as plain constants for legacy compatibility.
  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_BUSY = 2'b01;
  localparam logic [1:0] DIV_DONE = 2'b10;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU,
    OP_MTHI,
    OP_MTLO
  } op_class_e;

  function automatic op_class_e decode_op(input logic [ALU_OP_BUS_W-1:0] aluop);
    case (aluop)
      EXE_MULT_OP:  return OP_MULT;
      EXE_MULTU_OP: return OP_MULTU;
      EXE_DIV_OP:   return OP_DIV;
      EXE_DIVU_OP:  return OP_DIVU;
      EXE_MTHI_OP:  return OP_MTHI;
      EXE_MTLO_OP:  return OP_MTLO;
      default:      return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ex_muldiv_div_core.sv
// div_core: unsigned iterative restoring divider, one quotient bit per step.
// Only built when EX_MULDIV_DIV_EN is defined.
`ifdef EX_MULDIV_DIV_EN
module div_core
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              div0_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quot_o,
  output logic [DATA_W-1:0] rem_o,
  output logic              last_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] rem_q, quot_q, dvsr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W:0]   trial, diff;

  // Shift next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    trial = {rem_q, quot_q[DATA_W-1]};
    diff  = trial - {1'b0, dvsr_q};
  end

  // Operand load on start (divide-by-zero preloads the final result), then
  // one restoring step per enabled cycle; quotient bits shift in from the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (start_i) begin
      if (div0_i) begin
        rem_q  <= dividend_i;
        quot_q <= '1;
      end else begin
        rem_q  <= '0;
        quot_q <= dividend_i;
      end
      dvsr_q <= divisor_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      rem_q  <= diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
      quot_q <= {quot_q[DATA_W-2:0], ~diff[DATA_W]};
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign last_o = (cnt_q == LAST_STEP);

endmodule
`endif

// File: rtl/ex_muldiv.sv
// ex_muldiv: execute-stage multiply/divide unit owning architectural HI/LO.
// MULT/MULTU/MTHI/MTLO complete in one cycle; DIV/DIVU use div_core and hold
// the pipeline via stall_req_o. Divider present only with EX_MULDIV_DIV_EN.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [DATA_W-1:0] rdata1_i,
  input  logic [DATA_W-1:0] rdata2_i,
  input  logic              flush_i,
  output logic              stall_req_o,
  output logic              div_busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  op_class_e           op;
  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                sc_en, div_wr;
  logic [DATA_W-1:0]   div_hi, div_lo;

  assign op = decode_op(aluop_i);

  // Full-width products; sign-extending to 2*DATA_W makes the low half of an
  // unsigned multiply equal to the signed product.
  always_comb begin
    prod_s = {{DATA_W{rdata1_i[DATA_W-1]}}, rdata1_i} * {{DATA_W{rdata2_i[DATA_W-1]}}, rdata2_i};
    prod_u = {{DATA_W{1'b0}}, rdata1_i} * {{DATA_W{1'b0}}, rdata2_i};
  end

`ifdef EX_MULDIV_DIV_EN
  logic [1:0]        state_q, state_d;
  logic              busy_q, neg_quot_q, neg_rem_q;
  logic              is_div, div_signed, div_zero, stall;
  logic              core_start, core_step, core_last;
  logic [DATA_W-1:0] abs1, abs2, core_dividend, core_divisor, core_quot, core_rem;

  // Operand conditioning: magnitudes for DIV, raw values for DIVU and div-by-zero.
  always_comb begin
    is_div        = (op == OP_DIV) || (op == OP_DIVU);
    div_signed    = (op == OP_DIV);
    div_zero      = (rdata2_i == '0);
    abs1          = rdata1_i[DATA_W-1] ? -rdata1_i : rdata1_i;
    abs2          = rdata2_i[DATA_W-1] ? -rdata2_i : rdata2_i;
    core_dividend = (div_signed && !div_zero) ? abs1 : rdata1_i;
    core_divisor  = div_signed ? abs2 : rdata2_i;
  end

  // Divider FSM: accept in IDLE, iterate in BUSY, commit in DONE; flush aborts.
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    core_start = 1'b0;
    core_step  = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (is_div && !flush_i) begin
          stall      = 1'b1;
          core_start = 1'b1;
          state_d    = div_zero ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (flush_i) begin
          state_d = DIV_IDLE;
        end else begin
          stall     = 1'b1;
          core_step = 1'b1;
          if (core_last) state_d = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // State, busy flag and result sign flags captured at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      busy_q     <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == DIV_BUSY);
      if (core_start) begin
        neg_quot_q <= div_signed && !div_zero && (rdata1_i[DATA_W-1] ^ rdata2_i[DATA_W-1]);
        neg_rem_q  <= div_signed && !div_zero && rdata1_i[DATA_W-1];
      end
    end
  end

  div_core #(
    .DATA_W(DATA_W)
  ) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .start_i    (core_start),
    .div0_i     (div_zero),
    .step_i     (core_step),
    .dividend_i (core_dividend),
    .divisor_i  (core_divisor),
    .quot_o     (core_quot),
    .rem_o      (core_rem),
    .last_o     (core_last)
  );

  // Sign fix-up of the unsigned core result and write qualification.
  always_comb begin
    div_lo = neg_quot_q ? -core_quot : core_quot;
    div_hi = neg_rem_q ? -core_rem : core_rem;
    sc_en  = (state_q == DIV_IDLE) && !flush_i;
    div_wr = (state_q == DIV_DONE) && !flush_i;
  end

  assign stall_req_o = stall;
  assign div_busy_o  = busy_q;
`else
  // Divider absent: DIV/DIVU fall through as no-ops and never stall.
  always_comb begin
    sc_en  = !flush_i;
    div_wr = 1'b0;
    div_hi = '0;
    div_lo = '0;
  end

  assign stall_req_o = 1'b0;
  assign div_busy_o  = 1'b0;
`endif

  // HI/LO next-state: single-cycle ops in IDLE, divide result in DONE.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (sc_en) begin
      case (op)
        OP_MULT:  {hi_d, lo_d} = prod_s;
        OP_MULTU: {hi_d, lo_d} = prod_u;
        OP_MTHI:  hi_d = rdata1_i;
        OP_MTLO:  lo_d = rdata1_i;
        default:  ;
      endcase
    end
    if (div_wr) begin
      hi_d = div_hi;
      lo_d = div_lo;
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv. The driver issues one op per pipeline
// advance and pushes the reference model's expectation; the monitor pops and
// compares after each cycle in which stall_req_o was low.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  localparam logic [7:0] NOP_OP = 8'h00;
  localparam int NOFL = 99;
`ifdef EX_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop = '0;
  logic [31:0] rd1 = '0, rd2 = '0;
  logic        flush = 1'b0;
  logic        stall_req, div_busy;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  ex_muldiv #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop),
    .rdata1_i    (rd1),
    .rdata2_i    (rd2),
    .flush_i     (flush),
    .stall_req_o (stall_req),
    .div_busy_o  (div_busy),
    .hi_o        (hi),
    .lo_o        (lo)
  );

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  stalls;
    logic [7:0]  busy;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0, n_err = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: architectural effect of one op plus expected stall/busy cycles.
  task automatic predict(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at);
    exp_t   e;
    longint sa, sbv;
    bit     wr = 1'b1;
    bit     isdiv;
    int     st = 0, bz = 0;
    isdiv = DIV_EN && (op == EXE_DIV_OP || op == EXE_DIVU_OP);
    sa  = $signed(a);
    sbv = $signed(b);
    if (flush_at == 0) begin
      wr = 1'b0;
    end else if (isdiv) begin
      if (b == 0) begin
        st = 1;
        if (flush_at == 1) wr = 1'b0;
      end else if (flush_at <= 33) begin
        st = flush_at;
        bz = (flush_at > 32) ? 32 : flush_at;
        wr = 1'b0;
      end else begin
        st = 33;
        bz = 32;
      end
    end
    if (wr) begin
      case (op)
        EXE_MULT_OP:  {m_hi, m_lo} = 64'(sa * sbv);
        EXE_MULTU_OP: {m_hi, m_lo} = {32'd0, a} * {32'd0, b};
        EXE_MTHI_OP:  m_hi = a;
        EXE_MTLO_OP:  m_lo = a;
        EXE_DIVU_OP: if (DIV_EN) begin
          if (b == 0) begin m_lo = '1; m_hi = a; end
          else begin m_lo = a / b; m_hi = a % b; end
        end
        EXE_DIV_OP: if (DIV_EN) begin
          if (b == 0) begin m_lo = '1; m_hi = a; end
          else begin m_lo = 32'(sa / sbv); m_hi = 32'(sa % sbv); end
        end
        default: ;
      endcase
    end
    e.op = op; e.hi = m_hi; e.lo = m_lo; e.stalls = 8'(st); e.busy = 8'(bz);
    sb.push_back(e);
  endtask

  // Present one op and hold it until the pipeline advances; optionally flush
  // in the cycle with index flush_at (0 = acceptance cycle).
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at);
    bit s;
    bit done = 1'b0;
    int cyc = 0;
    predict(op, a, b, flush_at);
    aluop = op; rd1 = a; rd2 = b; flush = 1'b0;
    while (!done && cyc < 200) begin
      if (cyc == flush_at) flush = 1'b1;
      @(negedge clk);
      s = stall_req;
      @(posedge clk);
      #1;
      cyc++;
      if (!s) done = 1'b1;
    end
    flush = 1'b0;
    aluop = NOP_OP;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout op%02h: stall still high after %0d cycles, required release", op, cyc);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    rst = 1'b1; aluop = NOP_OP; flush = 1'b0;
    #1;
    chk("reset stall_req", 64'(stall_req), 64'd0);
    chk("reset div_busy", 64'(div_busy), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic reset_mid_div();
    issue(EXE_MTHI_OP, 32'hA5A5_A5A5, 32'd0, NOFL);
    issue(EXE_MTLO_OP, 32'h5A5A_5A5A, 32'd0, NOFL);
`ifdef EX_MULDIV_DIV_EN
    aluop = EXE_DIV_OP; rd1 = 32'd100; rd2 = 32'd7; flush = 1'b0;
    repeat (5) @(posedge clk);
    #1;
`else
    issue(EXE_DIV_OP, 32'd100, 32'd7, NOFL);
`endif
    apply_reset();
  endtask

  // Monitor: count stall/busy cycles per op; one cycle after an advance, compare.
  initial begin
    bit   pend = 1'b0;
    int   stc = 0, bsc = 0, p_st = 0, p_bs = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0; stc = 0; bsc = 0;
      end else begin
        if (pend) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected retire: got retire with hi=0x%0h lo=0x%0h, required none", hi, lo);
          end else begin
            e = sb.pop_front();
            chk($sformatf("op%02h hi", e.op), 64'(hi), 64'(e.hi));
            chk($sformatf("op%02h lo", e.op), 64'(lo), 64'(e.lo));
            chk($sformatf("op%02h stall cycles", e.op), 64'(p_st), 64'(e.stalls));
            chk($sformatf("op%02h busy cycles", e.op), 64'(p_bs), 64'(e.busy));
          end
          pend = 1'b0;
        end
        if (div_busy) bsc++;
        if (stall_req) stc++;
        else begin
          pend = 1'b1; p_st = stc; p_bs = bsc; stc = 0; bsc = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    issue(NOP_OP, 32'd0, 32'd0, NOFL);
    issue(EXE_DIVU_OP, 32'd100, 32'd7, NOFL);
    issue(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, NOFL);
    issue(EXE_MULT_OP, 32'hFFFF_FFFF, 32'd2, NOFL);
    issue(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'd2, NOFL);
    issue(EXE_DIVU_OP, 32'd5, 32'd0, NOFL);
    issue(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, NOFL);
    issue(EXE_MTHI_OP, 32'h1111_1111, 32'd0, NOFL);
    issue(EXE_DIV_OP, 32'd100, 32'd7, 10);
    issue(EXE_MTLO_OP, 32'h22, 32'd0, NOFL);
    issue(EXE_MULT_OP, 32'h1234, 32'h5678, 0);
    issue(EXE_DIVU_OP, 32'd1000, 32'd3, 33);
    issue(EXE_DIVU_OP, 32'd9, 32'd4, NOFL);
    issue(EXE_DIV_OP, 32'hFFFF_FFF7, 32'd4, NOFL);
    issue(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, NOFL);
    reset_mid_div();
    issue(NOP_OP, 32'd0, 32'd0, NOFL);
    issue(EXE_DIVU_OP, 32'd9, 32'd3, NOFL);

    for (int i = 0; i < 40; i++) begin
      logic [7:0]  op;
      logic [31:0] a, b;
      int          fa;
      int unsigned sel;
      sel = $urandom_range(0, 8);
      case (sel)
        0:       op = EXE_MULT_OP;
        1:       op = EXE_MULTU_OP;
        2, 3:    op = EXE_DIV_OP;
        4, 5:    op = EXE_DIVU_OP;
        6:       op = EXE_MTHI_OP;
        7:       op = EXE_MTLO_OP;
        default: op = 8'($urandom);
      endcase
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = '0;
      else if ($urandom_range(0, 4) == 0) b = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = '1; end
      fa = NOFL;
      if ($urandom_range(0, 6) == 0) fa = int'($urandom_range(0, 36));
      issue(op, a, b, fa);
    end

    @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Execute-stage multiply/divide unit with architectural HI/LO registers. It consumes the decoded operation and operands that the ID/EX pipeline register presents to the execute stage. MULT/MULTU/MTHI/MTLO complete in one cycle. DIV/DIVU run a multi-cycle shift-subtract divider and raise a stall request, so the ID/EX register holds its contents until the quotient and remainder are ready.

## Interface
Parameters:
- DATA_W, 32, operand and HI/LO width; the divider iterates DATA_W times.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- aluop_i  input  8  operation code from the ID/EX register's ALU-op output.
- rdata1_i  input  DATA_W  operand 1; dividend for DIV/DIVU, source for MTHI/MTLO.
- rdata2_i  input  DATA_W  operand 2; divisor for DIV/DIVU.
- flush_i  input  1  cancels an in-flight divide; no HI/LO write.
- stall_req_o  output  1  combinational request to freeze IF/ID/EX.
- div_busy_o  output  1  registered; high in BUSY.
- hi_o  output  DATA_W  registered HI.
- lo_o  output  DATA_W  registered LO.

## Operation
- Reset: HI=0, LO=0, state IDLE, div_busy_o=0, stall_req_o=0. Reset mid-divide aborts it and leaves no partial result.
- MULT: the signed 64-bit product of rdata1_i×rdata2_i is written as {HI,LO} at the edge ending the cycle the op is presented. MULTU is the same but unsigned. No stall.
- MTHI writes rdata1_i to HI; MTLO writes rdata1_i to LO. Single cycle.
- All other aluop values leave HI and LO unchanged.
- DIV/DIVU FSM, states IDLE, BUSY, DONE:
  - IDLE with a DIV/DIVU op, divisor≠0: stall_req_o=1; latch |dividend| and |divisor| (DIVU: raw values) plus sign flags; counter=0; go to BUSY.
  - IDLE with a DIV/DIVU op, divisor=0: stall_req_o=1; go to DONE with quotient=all ones and remainder=dividend (raw).
  - BUSY: stall_req_o=1. Each cycle performs one restoring shift-subtract step on the DATA_W+1-bit partial remainder. Exit to DONE after the step where counter=DATA_W-1.
  - DONE: stall_req_o=0. For DIV, apply signs: quotient is negated if the operand signs differ; remainder takes the dividend's sign. Write HI=remainder and LO=quotient at the edge, then return to IDLE. The pipeline advances on that same edge, so the divide is not re-accepted.
- flush_i in BUSY or DONE: stall_req_o=0 combinationally, no HI/LO write, next state IDLE. flush_i in IDLE suppresses acceptance and any single-cycle write.
- The most negative dividend divided by -1 (DIV) produces quotient 0x80000000 and remainder 0. No trap.

## Timing
- Single-cycle ops: result visible on hi_o/lo_o in the next cycle, so an MFHI/MFLO immediately following reads the new value.
- DIV/DIVU: stall_req_o is high for 1 accept cycle + DATA_W BUSY cycles (33 total). DONE is the 34th cycle. HI/LO update at the end of DONE.
- Divide by zero: 1 stall cycle, then DONE.
- div_busy_o rises on the edge entering BUSY and falls on the edge entering DONE.
- Back-to-back divides: the second is accepted in the cycle after DONE.

## Configuration
- EX_MULDIV_DIV_EN defined: divider FSM and div_core are built as above.
- EX_MULDIV_DIV_EN undefined:
  - DIV/DIVU are treated as no-ops.
  - HI and LO are unchanged.
  - stall_req_o and div_busy_o are tied to 0.
  - No divider logic is synthesised.

## Structure
- defines.v holds EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_MTHI_OP, EXE_MTLO_OP, and the state encodings DIV_IDLE/DIV_BUSY/DIV_DONE. It also holds the existing RegBus/AluOpBus/ZeroWord constants.
- Sub-module div_core is the unsigned iterative divider: start, operands, step counter, quotient/remainder, done. ex_muldiv wraps it with sign handling, the FSM, flush, and HI/LO.

## Test plan
- DIVU 100/7 → stall_req_o high exactly 33 cycles; then LO=14 (0x0000000E), HI=2.
- DIV 0xFFFFFFF9 (-7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MULT 0xFFFFFFFF×2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU of the same operands → HI=1, LO=0xFFFFFFFE. No stall in either case.
- DIVU 5/0 → 1 stall cycle; then LO=0xFFFFFFFF, HI=5.
- Preload HI=0x11111111 via MTHI, start DIV 100/7, assert flush_i at BUSY cycle 10:
  - stall_req_o drops in the same cycle;
  - HI stays 0x11111111;
  - a following MTLO 0x22 gives LO=0x22.
- Assert rst at BUSY cycle 5 → state IDLE, HI=LO=0, stall_req_o=0. A subsequent DIVU 9/3 gives LO=3, HI=0.
